// File: rtl/rv_pkg.sv
// Shared RISC-V core definitions used by the writeback path.
package rv_pkg;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] X0 = 5'd0;

  typedef enum logic {
    WB_NORMAL = 1'b0,
    WB_DRAIN  = 1'b1
  } wb_state_t;
endpackage

// File: rtl/wb_fifo.sv
// Small first-word-fall-through FIFO buffering long-latency results ahead of the write port.
module wb_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 37
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q;

  assign dout  = mem_q[rptr_q];
  assign count = count_q;
  assign full  = (count_q == FULL_C);
  assign empty = (count_q == '0);

  // Storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= din;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Owns the register file write port: merges ALU results with buffered long-latency
// results, with a drain mode so the buffered stream cannot starve.
module regfile_wb_arbiter #(
  parameter int XLEN  = rv_pkg::XLEN,
  parameter int DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          alu_valid,
  output logic                          alu_ready,
  input  logic [rv_pkg::REG_ADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]               alu_data,
  input  logic                          lq_valid,
  output logic                          lq_ready,
  input  logic [rv_pkg::REG_ADDR_W-1:0] lq_rd,
  input  logic [XLEN-1:0]               lq_data,
  output logic                          we3,
  output logic [rv_pkg::REG_ADDR_W-1:0] rd,
  output logic [XLEN-1:0]               wd3,
  output logic                          busy
);
  import rv_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int W  = REG_ADDR_W + XLEN;
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  localparam logic [CW-1:0] HALF_C = CW'(DEPTH / 2);

  wb_state_t               state_q, state_d;
  logic                    we3_q, we3_d;
  logic [REG_ADDR_W-1:0]   rd_q, rd_d;
  logic [XLEN-1:0]         wd3_q, wd3_d;

  logic                    push, pop, full, empty;
  logic [CW-1:0]           count, count_post;
  logic [W-1:0]            dout;
  logic                    alu_wr, lq_xfer;

  assign alu_ready = resetn && (state_q == WB_NORMAL);
  assign lq_ready  = resetn && !full;
  assign alu_wr    = alu_valid && alu_ready && (alu_rd != X0);
  assign lq_xfer   = lq_valid && lq_ready;
  assign push      = lq_xfer && (lq_rd != X0);
  // In DRAIN alu_ready is low, so alu_wr is low and the head pops every cycle.
  assign pop       = !empty && !alu_wr;
  assign count_post = count + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};

  wb_fifo #(.DEPTH(DEPTH), .W(W)) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (push),
    .pop    (pop),
    .din    ({lq_rd, lq_data}),
    .dout   (dout),
    .count  (count),
    .full   (full),
    .empty  (empty)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      WB_NORMAL: if (count == FULL_C)      state_d = WB_DRAIN;
      WB_DRAIN:  if (count_post <= HALF_C) state_d = WB_NORMAL;
      default:   state_d = WB_NORMAL;
    endcase
  end

  always_comb begin
    we3_d = alu_wr || pop;
    rd_d  = rd_q;
    wd3_d = wd3_q;
    if (alu_wr) begin
      rd_d  = alu_rd;
      wd3_d = alu_data;
    end else if (pop) begin
      {rd_d, wd3_d} = dout;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= WB_NORMAL;
      we3_q   <= 1'b0;
      rd_q    <= '0;
      wd3_q   <= '0;
    end else begin
      state_q <= state_d;
      we3_q   <= we3_d;
      rd_q    <= rd_d;
      wd3_q   <= wd3_d;
    end
  end

  assign we3  = we3_q;
  assign rd   = rd_q;
  assign wd3  = wd3_q;
  assign busy = !empty || we3_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: inputs change and outputs are sampled on negedge.
module tb_regfile_wb_arbiter;
  import rv_pkg::*;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            resetn;
  logic            alu_valid, alu_ready, lq_valid, lq_ready;
  logic [4:0]      alu_rd, lq_rd, rd;
  logic [XLEN-1:0] alu_data, lq_data, wd3;
  logic            we3, busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .lq_valid  (lq_valid),
    .lq_ready  (lq_ready),
    .lq_rd     (lq_rd),
    .lq_data   (lq_data),
    .we3       (we3),
    .rd        (rd),
    .wd3       (wd3),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_wr(input string tag, input logic [4:0] r, input logic [31:0] d);
    chk({tag, "_we3"}, 64'(we3), 64'd1);
    chk({tag, "_rd"},  64'(rd),  64'(r));
    chk({tag, "_wd3"}, 64'(wd3), 64'(d));
  endtask

  task automatic drive_alu(input logic v, input logic [4:0] r, input logic [31:0] d);
    alu_valid = v; alu_rd = r; alu_data = d;
  endtask

  task automatic drive_lq(input logic v, input logic [4:0] r, input logic [31:0] d);
    lq_valid = v; lq_rd = r; lq_data = d;
  endtask

  initial begin
    resetn = 1'b0;
    drive_alu(1'b1, 5'd3, 32'h1111_1111);
    drive_lq(1'b1, 5'd4, 32'h2222_2222);

    // Reset held 3 cycles with both sources valid
    repeat (3) @(negedge clk);
    chk("rst_we3",       64'(we3),       64'd0);
    chk("rst_alu_ready", 64'(alu_ready), 64'd0);
    chk("rst_lq_ready",  64'(lq_ready),  64'd0);
    chk("rst_busy",      64'(busy),      64'd0);
    chk("rst_rd",        64'(rd),        64'd0);
    chk("rst_wd3",       64'(wd3),       64'd0);
    resetn = 1'b1;
    drive_alu(1'b0, 5'd0, 32'd0);
    drive_lq(1'b0, 5'd0, 32'd0);
    #1;
    chk("rel_alu_ready", 64'(alu_ready), 64'd1);
    chk("rel_lq_ready",  64'(lq_ready),  64'd1);

    // ALU only
    @(negedge clk);
    drive_alu(1'b1, 5'd5, 32'hDEAD_BEEF);
    @(negedge clk);
    chk_wr("alu", 5'd5, 32'hDEAD_BEEF);
    drive_alu(1'b0, 5'd0, 32'd0);
    @(negedge clk);
    chk("alu_idle_we3",  64'(we3),  64'd0);
    chk("alu_idle_busy", 64'(busy), 64'd0);

    // x0 destinations are accepted and dropped
    drive_alu(1'b1, 5'd0, 32'hAAAA_0000);
    drive_lq(1'b1, 5'd0, 32'hBBBB_0000);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("x0_alu_ready", 64'(alu_ready), 64'd1);
      chk("x0_lq_ready",  64'(lq_ready),  64'd1);
      chk("x0_we3",       64'(we3),       64'd0);
      chk("x0_busy",      64'(busy),      64'd0);
    end
    drive_alu(1'b0, 5'd0, 32'd0);
    drive_lq(1'b0, 5'd0, 32'd0);
    @(negedge clk);
    chk("x0_after_we3", 64'(we3), 64'd0);

    // Contention: ALU wins while lq fills the FIFO
    for (int k = 0; k < 4; k++) begin
      drive_alu(1'b1, 5'(10 + k), 32'hA0 + 32'(k));
      drive_lq(1'b1, 5'(k + 1), 32'h100 + 32'(k + 1));
      @(negedge clk);
      chk_wr("cont_alu", 5'(10 + k), 32'hA0 + 32'(k));
      chk("cont_lq_ready", 64'(lq_ready), (k < 3) ? 64'd1 : 64'd0);
    end
    drive_lq(1'b0, 5'd0, 32'd0);
    drive_alu(1'b1, 5'd20, 32'hC0DE);
    chk("full_alu_ready", 64'(alu_ready), 64'd1);
    @(negedge clk);
    chk_wr("full_alu", 5'd20, 32'hC0DE);
    chk("drain_alu_ready", 64'(alu_ready), 64'd0);
    chk("drain_lq_ready",  64'(lq_ready),  64'd0);
    @(negedge clk);
    chk_wr("drain1", 5'd1, 32'h101);
    chk("drain1_alu_ready", 64'(alu_ready), 64'd0);
    chk("drain1_lq_ready",  64'(lq_ready),  64'd1);
    @(negedge clk);
    chk_wr("drain2", 5'd2, 32'h102);
    chk("resume_alu_ready", 64'(alu_ready), 64'd1);
    chk("resume_count",     64'(dut.u_fifo.count), 64'd2);

    // Same-cycle push and pop with FIFO holding rd 3,4
    drive_alu(1'b0, 5'd0, 32'd0);
    drive_lq(1'b1, 5'd7, 32'h107);
    @(negedge clk);
    chk_wr("pp3", 5'd3, 32'h103);
    chk("pp_count", 64'(dut.u_fifo.count), 64'd2);
    drive_lq(1'b0, 5'd0, 32'd0);
    @(negedge clk);
    chk_wr("pp4", 5'd4, 32'h104);
    @(negedge clk);
    chk_wr("pp7", 5'd7, 32'h107);
    chk("pp_busy_last", 64'(busy), 64'd1);
    @(negedge clk);
    chk("pp_done_we3",  64'(we3),  64'd0);
    chk("pp_done_busy", 64'(busy), 64'd0);

    // Fill again, enter DRAIN, then reset mid-drain
    for (int k = 0; k < 4; k++) begin
      drive_alu(1'b1, 5'd9, 32'h900 + 32'(k));
      drive_lq(1'b1, 5'(11 + k), 32'h200 + 32'(k));
      @(negedge clk);
    end
    drive_lq(1'b0, 5'd0, 32'd0);
    @(negedge clk);
    chk("md_state", 64'(dut.state_q), 64'(WB_DRAIN));
    chk("md_count", 64'(dut.u_fifo.count), 64'd4);
    resetn = 1'b0;
    @(negedge clk);
    chk("md_rst_we3",   64'(we3),   64'd0);
    chk("md_rst_count", 64'(dut.u_fifo.count), 64'd0);
    chk("md_rst_state", 64'(dut.state_q), 64'(WB_NORMAL));
    chk("md_rst_busy",  64'(busy),  64'd0);
    chk("md_rst_alu_ready", 64'(alu_ready), 64'd0);
    resetn = 1'b1;
    drive_alu(1'b0, 5'd0, 32'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("md_post_we3",  64'(we3),  64'd0);
      chk("md_post_busy", 64'(busy), 64'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
